stereo_pan_mixer: RTL
=====================

Name: stereo_pan_mixer

Overview:
- Parametrised successor to the fixed three-voice stereo conditioner.
- Mixes NUM_VOICES note-player voices into a 16-bit left/right sample pair.
- Each voice has its own pan position; a stereo_on=0 mono fallback sends the full mix to both channels.
- Time-multiplexes one multiply-accumulate per voice per clock, triggered by the codec sample strobe. Sits between the note players and the codec interface.

Parameters:
- NUM_VOICES, 3, number of voice inputs (1..16).
- PAN_W, 4, pan resolution; full-scale gain G = 2^PAN_W.
- HEADROOM_SH, 1, extra arithmetic right shift applied after the gain normalisation.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- new_sample_in  in  1  one-cycle strobe: capture the voices and start a mix.
- note_data  in  17*NUM_VOICES  voice v at [17v+16:17v]; bit 16 = voice active, [15:0] = signed sample.
- pan  in  (PAN_W+1)*NUM_VOICES  voice v pan, 0 = hard left, G = hard right; values > G are clamped to G.
- stereo_on  in  1  1 = per-voice pan, 0 = mono (both gains = G).
- overrun_clr  in  1  clears the overrun flag.
- sample_l  out  16  signed left output sample, registered.
- sample_r  out  16  signed right output sample, registered.
- new_sample_out  out  1  one-cycle pulse when sample_l and sample_r update.
- busy  out  1  high while a mix is in progress.
- overrun  out  1  sticky flag: a strobe arrived while busy.

Behaviour:
- Reset (asynchronous): sample_l=0, sample_r=0, new_sample_out=0, busy=0, overrun=0, accumulators=0, FSM=IDLE.
- The FSM has three states: IDLE, ACCUM, OUT.
- IDLE + new_sample_in:
  - Latch note_data, pan and stereo_on into shadow registers.
  - Clear both accumulators; voice index = 0; go to ACCUM; busy=1.
  - Mid-mix input changes have no effect on the current mix.
- ACCUM, one voice per cycle:
  - gain_r = clamp(pan_v); gain_l = G - gain_r.
  - If the latched stereo_on = 0, gain_l = gain_r = G.
  - Inactive voice (bit 16 = 0): contributes 0.
  - Active voice: acc_l += sample*gain_l, acc_r += sample*gain_r.
  - Products and sums are signed. Accumulator width is 16+PAN_W+1+clog2(NUM_VOICES)+1, so the accumulators never overflow.
  - After voice NUM_VOICES-1, go to OUT.
- OUT:
  - Each channel = acc >>> (PAN_W+HEADROOM_SH), arithmetic shift (floor).
  - Saturate to [-32768, 32767] and register into sample_l/sample_r.
  - Pulse new_sample_out for one cycle; busy=0; return to IDLE.
- Latency: strobe sampled at edge T; outputs and new_sample_out become valid after edge T+NUM_VOICES+1. Between updates, outputs hold their previous values.
- Strobe while busy:
  - The strobe is ignored and overrun is set.
  - The in-flight mix completes with its originally latched data.
- A strobe coincident with the OUT cycle is also ignored and sets overrun.
- overrun_clr and a new overrun event in the same cycle: set wins.
- Reset mid-ACCUM: immediate return to reset values; no new_sample_out pulse.

Decomposition:
- Shared package mixer_pkg holds:
  - FSM state enum (IDLE, ACCUM, OUT);
  - VOICE_W=17 and SAMPLE_W=16 constants;
  - a saturate-to-16-bit function;
  - a pan clamp function.
- One sub-module, voice_pan_mac. Combinational: inputs are the selected voice, its pan and mono_mode; outputs are the two signed products, with the active-bit gating applied.

Test Plan (NUM_VOICES=3, PAN_W=4, HEADROOM_SH=1):
- Mono mix:
  - Stimulus: stereo_on=0; all voices active; samples 1000, 2000, -500; strobe.
  - Response: sample_l = sample_r = 1250; new_sample_out pulses exactly 4 cycles after the strobe edge; busy high for the intervening cycles.
- Stereo pan:
  - Stimulus: stereo_on=1; same samples; pans 0, 16, 8.
  - Response: sample_l = 375, sample_r = 875.
- Saturation and clamp:
  - Stimulus: mono; all voices 32767.
  - Response: both channels 32767.
  - Stimulus: all voices -32768.
  - Response: both channels -32768.
  - Stimulus: stereo; pan=20 on voice 0, sample 1000, others inactive.
  - Response: l = 0, r = 500.
- Inactive voices:
  - Stimulus: voice b has bit 16 = 0 with sample 2000; mono.
  - Response: both channels 250.
  - Stimulus: all inputs 0.
  - Response: both channels 0.
- Overrun:
  - Stimulus: second strobe 2 cycles after the first, with changed data.
  - Response: output reflects the first data only; overrun=1 and stays set.
  - Stimulus: overrun_clr.
  - Response: overrun=0.
  - Stimulus: overrun_clr simultaneous with a new overrun.
  - Response: overrun stays 1.
- Reset mid-mix:
  - Stimulus: assert reset during ACCUM.
  - Response: outputs 0, busy 0, no new_sample_out pulse.
  - Stimulus: next strobe after reset release.
  - Response: mix completes normally.

Source files
------------

// File: rtl/mixer_pkg.sv
// rtl/mixer_pkg.sv - shared types, constants and helpers for the stereo pan mixer
//   mix_state_t : mixer sequencer states
//   VOICE_W     : width of one voice word (active bit + sample)
//   SAMPLE_W    : signed sample width
//   sat16       : clip a wide signed value to the 16-bit sample range
//   clamp_pan   : limit a pan position to the full-scale gain

package mixer_pkg;

   typedef enum logic [1:0] {
      IDLE,
      ACCUM,
      OUT
   } mix_state_t;

   localparam int VOICE_W  = 17;
   localparam int SAMPLE_W = 16;

   function automatic logic signed [SAMPLE_W-1:0] sat16(input logic signed [63:0] v);
      if (v > 64'sd32767) begin
         return 16'sh7fff;
      end else if (v < -64'sd32768) begin
         return 16'sh8000;
      end else begin
         return v[SAMPLE_W-1:0];
      end
   endfunction

   function automatic int unsigned clamp_pan(input int unsigned p, input int unsigned g);
      return (p > g) ? g : p;
   endfunction

endpackage

// File: rtl/voice_pan_mac.sv
// rtl/voice_pan_mac.sv - per-voice pan gain and signed product generation
//   voice     : in  selected voice word, bit 16 = active, [15:0] = signed sample
//   pan       : in  pan position, 0 = hard left, 2^PAN_W = hard right, larger clamps
//   mono_mode : in  1 = both gains at full scale
//   prod_l    : out signed sample * left gain, zero for an inactive voice
//   prod_r    : out signed sample * right gain, zero for an inactive voice

module voice_pan_mac
   import mixer_pkg::*;
#(
   parameter int PAN_W  = 4,
   parameter int PROD_W = SAMPLE_W + PAN_W + 2
) (
   input  logic [VOICE_W-1:0]       voice,
   input  logic [PAN_W:0]           pan,
   input  logic                     mono_mode,
   output logic signed [PROD_W-1:0] prod_l,
   output logic signed [PROD_W-1:0] prod_r
);

   localparam int unsigned FULL = 1 << PAN_W;

   logic [PAN_W:0]           gain_l;
   logic [PAN_W:0]           gain_r;
   logic signed [PROD_W-1:0] sample_ext;
   logic signed [PROD_W-1:0] gain_l_ext;
   logic signed [PROD_W-1:0] gain_r_ext;

   always_comb begin
      gain_r = (PAN_W+1)'(clamp_pan(32'(pan), FULL));
      gain_l = (PAN_W+1)'(FULL) - gain_r;
      if (mono_mode) begin
         gain_l = (PAN_W+1)'(FULL);
         gain_r = (PAN_W+1)'(FULL);
      end

      // Gains are unsigned magnitudes; a zero guard bit keeps them positive
      // once they enter the signed multiply.
      sample_ext = PROD_W'(signed'(voice[SAMPLE_W-1:0]));
      gain_l_ext = PROD_W'({1'b0, gain_l});
      gain_r_ext = PROD_W'({1'b0, gain_r});

      prod_l = '0;
      prod_r = '0;
      if (voice[VOICE_W-1]) begin
         prod_l = sample_ext * gain_l_ext;
         prod_r = sample_ext * gain_r_ext;
      end
   end

endmodule

// File: rtl/stereo_pan_mixer.sv
// rtl/stereo_pan_mixer.sv - time-multiplexed N-voice stereo pan mixer
//   clk            : in  system clock
//   reset          : in  asynchronous active-high reset
//   new_sample_in  : in  strobe, capture voices and start a mix
//   note_data      : in  voice v at [17v+16:17v], bit 16 active, [15:0] signed sample
//   pan            : in  voice v pan at [(PAN_W+1)v +: PAN_W+1]
//   stereo_on      : in  1 = per-voice pan, 0 = mono
//   overrun_clr    : in  clear the overrun flag
//   sample_l       : out signed left sample, registered
//   sample_r       : out signed right sample, registered
//   new_sample_out : out one-cycle pulse when sample_l/sample_r update
//   busy           : out mix in progress
//   overrun        : out sticky, strobe arrived while a mix was in flight

module stereo_pan_mixer
   import mixer_pkg::*;
#(
   parameter int NUM_VOICES  = 3,
   parameter int PAN_W       = 4,
   parameter int HEADROOM_SH = 1
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic                            new_sample_in,
   input  logic [VOICE_W*NUM_VOICES-1:0]   note_data,
   input  logic [(PAN_W+1)*NUM_VOICES-1:0] pan,
   input  logic                            stereo_on,
   input  logic                            overrun_clr,
   output logic signed [SAMPLE_W-1:0]      sample_l,
   output logic signed [SAMPLE_W-1:0]      sample_r,
   output logic                            new_sample_out,
   output logic                            busy,
   output logic                            overrun
);

   localparam int PROD_W = SAMPLE_W + PAN_W + 2;
   localparam int ACC_W  = SAMPLE_W + PAN_W + 1 + $clog2(NUM_VOICES) + 1;
   localparam int IDX_W  = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
   localparam int SHIFT  = PAN_W + HEADROOM_SH;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VOICES - 1);

   mix_state_t                       state;
   logic [IDX_W-1:0]                 idx;
   logic [VOICE_W*NUM_VOICES-1:0]    note_sh;
   logic [(PAN_W+1)*NUM_VOICES-1:0]  pan_sh;
   logic                             stereo_sh;
   logic signed [ACC_W-1:0]          acc_l;
   logic signed [ACC_W-1:0]          acc_r;

   logic [VOICE_W-1:0]               cur_voice;
   logic [PAN_W:0]                   cur_pan;
   logic signed [PROD_W-1:0]         prod_l;
   logic signed [PROD_W-1:0]         prod_r;
   logic signed [SAMPLE_W-1:0]       sat_l;
   logic signed [SAMPLE_W-1:0]       sat_r;

   // Voice selection works from the shadow copy so mid-mix input changes
   // cannot leak into the running mix.
   always_comb begin
      cur_voice = note_sh[32'(idx)*VOICE_W +: VOICE_W];
      cur_pan   = pan_sh[32'(idx)*(PAN_W+1) +: PAN_W+1];
   end

   voice_pan_mac #(
      .PAN_W  (PAN_W),
      .PROD_W (PROD_W)
   ) u_mac (
      .voice     (cur_voice),
      .pan       (cur_pan),
      .mono_mode (~stereo_sh),
      .prod_l    (prod_l),
      .prod_r    (prod_r)
   );

   // Arithmetic shift floors toward minus infinity, matching the normalisation.
   always_comb begin
      sat_l = sat16(64'(acc_l >>> SHIFT));
      sat_r = sat16(64'(acc_r >>> SHIFT));
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state          <= IDLE;
         idx            <= '0;
         note_sh        <= '0;
         pan_sh         <= '0;
         stereo_sh      <= 1'b0;
         acc_l          <= '0;
         acc_r          <= '0;
         sample_l       <= '0;
         sample_r       <= '0;
         new_sample_out <= 1'b0;
         busy           <= 1'b0;
         overrun        <= 1'b0;
      end else begin
         new_sample_out <= 1'b0;

         // A strobe outside IDLE (ACCUM or OUT) is dropped; setting beats clearing.
         if (new_sample_in && (state != IDLE)) begin
            overrun <= 1'b1;
         end else if (overrun_clr) begin
            overrun <= 1'b0;
         end

         case (state)
            IDLE: begin
               if (new_sample_in) begin
                  note_sh   <= note_data;
                  pan_sh    <= pan;
                  stereo_sh <= stereo_on;
                  acc_l     <= '0;
                  acc_r     <= '0;
                  idx       <= '0;
                  busy      <= 1'b1;
                  state     <= ACCUM;
               end
            end
            ACCUM: begin
               acc_l <= acc_l + ACC_W'(prod_l);
               acc_r <= acc_r + ACC_W'(prod_r);
               if (idx == LAST_IDX) begin
                  state <= OUT;
               end else begin
                  idx <= idx + 1'b1;
               end
            end
            OUT: begin
               sample_l       <= sat_l;
               sample_r       <= sat_r;
               new_sample_out <= 1'b1;
               busy           <= 1'b0;
               state          <= IDLE;
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule
